// File: rtl/dmem_arbiter.sv
// dmem_arbiter: round-robin two-port data-memory arbiter with sub-word load extraction and read-modify-write stores
module dmem_arbiter (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        a_req,
  input  logic        a_we,
  input  logic [2:0]  a_funct3,
  input  logic [11:0] a_addr,
  input  logic [31:0] a_wdata,
  input  logic        b_req,
  input  logic        b_we,
  input  logic [2:0]  b_funct3,
  input  logic [11:0] b_addr,
  input  logic [31:0] b_wdata,
  output logic        a_gnt,
  output logic        b_gnt,
  output logic        a_done,
  output logic        b_done,
  output logic        a_err,
  output logic        b_err,
  output logic [31:0] a_rdata,
  output logic [31:0] b_rdata,
  output logic        mem_read,
  output logic        mem_write,
  output logic [11:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);
  typedef enum logic [1:0] {IDLE, RD, RMW_RD, WR} state_t;
  state_t state_q, state_d;
  logic port_q, port_d, prio_b_q, prio_b_d, we_q, we_d;
  logic [2:0] f3_q, f3_d;
  logic [11:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic a_done_q, b_done_q, a_err_q, b_err_q;
  logic [31:0] a_rdata_q, b_rdata_q;
  logic pick_b, grant, g_we, g_err, fin, fin_port, fin_err;
  logic [2:0] g_f3;
  logic [11:0] g_addr;
  logic [31:0] g_wdata, fin_data, sh_word, load_val, merged;
  logic [7:0] ld_b;
  logic [15:0] ld_h;
  function automatic logic bad(input logic we, input logic [2:0] f3, input logic [1:0] a);
    return f3 == 3'b011 || f3[2:1] == 2'b11 || (we && f3[2]) ||
           (f3[1:0] == 2'b01 && a[0]) || (f3[1:0] == 2'b10 && a != 2'b00);
  endfunction
  assign pick_b  = b_req & (~a_req | prio_b_q);
  assign grant   = (state_q == IDLE) & (a_req | b_req);
  assign g_we    = pick_b ? b_we : a_we;
  assign g_f3    = pick_b ? b_funct3 : a_funct3;
  assign g_addr  = pick_b ? b_addr : a_addr;
  assign g_wdata = pick_b ? b_wdata : a_wdata;
  assign g_err   = bad(g_we, g_f3, g_addr[1:0]);
  assign a_gnt   = rst_n & grant & ~pick_b;
  assign b_gnt   = rst_n & grant & pick_b;
  assign sh_word = mem_rdata >> {addr_q[1:0], 3'b000};
  assign ld_b    = sh_word[7:0];
  assign ld_h    = addr_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
  assign load_val = f3_q == 3'b000 ? {{24{ld_b[7]}}, ld_b} :
                    f3_q == 3'b100 ? {24'b0, ld_b} :
                    f3_q == 3'b001 ? {{16{ld_h[15]}}, ld_h} :
                    f3_q == 3'b101 ? {16'b0, ld_h} : mem_rdata;
  always_comb begin
    merged = mem_rdata;
    for (int k = 0; k < 4; k++)
      if (f3_q[0] ? addr_q[1] == k[1] : addr_q[1:0] == k[1:0])
        merged[8*k +: 8] = (f3_q[0] & k[0]) ? wdata_q[15:8] : wdata_q[7:0];
  end
  always_comb begin
    state_d  = state_q;
    port_d   = port_q;
    prio_b_d = prio_b_q;
    we_d     = we_q;
    f3_d     = f3_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    fin      = 1'b0;
    fin_port = port_q;
    fin_err  = 1'b0;
    fin_data = 32'b0;
    case (state_q)
      IDLE: if (grant) begin
        port_d   = pick_b;
        prio_b_d = ~pick_b;
        we_d     = g_we;
        f3_d     = g_f3;
        addr_d   = g_addr;
        wdata_d  = g_wdata;
        fin      = g_err;
        fin_port = pick_b;
        fin_err  = g_err;
        state_d  = g_err ? IDLE : !g_we ? RD : g_f3 == 3'b010 ? WR : RMW_RD;
      end
      RD: begin
        fin      = 1'b1;
        fin_data = load_val;
        state_d  = IDLE;
      end
      RMW_RD: begin
        wdata_d = merged;
        state_d = WR;
      end
      default: begin
        fin     = 1'b1;
        state_d = IDLE;
      end
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      port_q    <= 1'b0;
      prio_b_q  <= 1'b0;
      we_q      <= 1'b0;
      f3_q      <= 3'b0;
      addr_q    <= 12'b0;
      wdata_q   <= 32'b0;
      a_done_q  <= 1'b0;
      b_done_q  <= 1'b0;
      a_err_q   <= 1'b0;
      b_err_q   <= 1'b0;
      a_rdata_q <= 32'b0;
      b_rdata_q <= 32'b0;
    end else begin
      state_q   <= state_d;
      port_q    <= port_d;
      prio_b_q  <= prio_b_d;
      we_q      <= we_d;
      f3_q      <= f3_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      a_done_q  <= fin & ~fin_port;
      b_done_q  <= fin & fin_port;
      a_err_q   <= fin & ~fin_port & fin_err;
      b_err_q   <= fin & fin_port & fin_err;
      a_rdata_q <= (fin & ~fin_port) ? fin_data : a_rdata_q;
      b_rdata_q <= (fin & fin_port) ? fin_data : b_rdata_q;
    end
  end
  assign a_done    = a_done_q;
  assign b_done    = b_done_q;
  assign a_err     = a_err_q;
  assign b_err     = b_err_q;
  assign a_rdata   = a_rdata_q;
  assign b_rdata   = b_rdata_q;
  assign mem_read  = (state_q == RD) | (state_q == RMW_RD);
  assign mem_write = state_q == WR;
  assign mem_addr  = {addr_q[11:2], 2'b00};
  assign mem_wdata = wdata_q;
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: table-driven scoreboard bench for dmem_arbiter against a behavioural word memory
module tb_dmem_arbiter;
  logic clk = 1'b0, rst_n = 1'b0;
  logic a_req = 0, a_we = 0, b_req = 0, b_we = 0;
  logic [2:0] a_funct3 = 0, b_funct3 = 0;
  logic [11:0] a_addr = 0, b_addr = 0;
  logic [31:0] a_wdata = 0, b_wdata = 0;
  logic a_gnt, b_gnt, a_done, b_done, a_err, b_err, mem_read, mem_write;
  logic [31:0] a_rdata, b_rdata, mem_wdata, mem_rdata;
  logic [11:0] mem_addr;
  logic [31:0] mem [1024];
  typedef struct {
    logic port; logic we; logic [2:0] f3; logic [11:0] addr; logic [31:0] wdata;
    logic err; logic [31:0] rdata; logic [31:0] wword; int lat;
  } vec_t;
  typedef struct {logic port; logic err; logic chk_rd; logic [31:0] rdata; int gcyc; int lat;} exp_t;
  exp_t sb[$];
  vec_t tbl[24];
  int checks = 0, errors = 0, cyc = 0, rd_cnt = 0, wr_cnt = 0, overlap_cnt = 0, done_cnt = 0;
  logic [31:0] last_wdata;
  logic [11:0] last_waddr;
  logic order[$];
  dmem_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .a_req(a_req), .a_we(a_we), .a_funct3(a_funct3), .a_addr(a_addr), .a_wdata(a_wdata),
    .b_req(b_req), .b_we(b_we), .b_funct3(b_funct3), .b_addr(b_addr), .b_wdata(b_wdata),
    .a_gnt(a_gnt), .b_gnt(b_gnt), .a_done(a_done), .b_done(b_done), .a_err(a_err), .b_err(b_err),
    .a_rdata(a_rdata), .b_rdata(b_rdata), .mem_read(mem_read), .mem_write(mem_write),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );
  always #5 clk = ~clk;
  assign mem_rdata = mem[mem_addr[11:2]];
  always @(posedge clk) if (mem_write) mem[mem_addr[11:2]] <= mem_wdata;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask
  always @(negedge clk) begin
    if (mem_read) rd_cnt++;
    if (mem_write) begin
      wr_cnt++;
      last_wdata = mem_wdata;
      last_waddr = mem_addr;
    end
    if (mem_read && mem_write) overlap_cnt++;
    if (a_done || b_done) begin
      done_cnt++;
      if (sb.size() == 0) chk("unexpected_done", 32'd1, 32'd0);
      else begin
        exp_t e;
        e = sb.pop_front();
        chk("done_port", {31'b0, b_done}, {31'b0, e.port});
        chk("err", {31'b0, e.port ? b_err : a_err}, {31'b0, e.err});
        if (e.chk_rd) chk("rdata", e.port ? b_rdata : a_rdata, e.rdata);
        chk("latency", cyc - e.gcyc, e.lat);
      end
    end
  end
  task automatic drain();
    for (int w = 0; w < 10 && sb.size() > 0; w++) begin
      @(negedge clk);
      #2;
    end
    chk("drain_timeout", sb.size(), 0);
    sb.delete();
  endtask
  task automatic issue(input vec_t v);
    int r0, w0;
    logic got;
    @(negedge clk);
    if (v.port) begin
      b_we = v.we; b_funct3 = v.f3; b_addr = v.addr; b_wdata = v.wdata; b_req = 1;
    end else begin
      a_we = v.we; a_funct3 = v.f3; a_addr = v.addr; a_wdata = v.wdata; a_req = 1;
    end
    r0 = rd_cnt;
    w0 = wr_cnt;
    got = 0;
    for (int w = 0; w < 20 && !got; w++) begin
      #1;
      if (v.port ? b_gnt : a_gnt) got = 1;
      else @(negedge clk);
    end
    chk("gnt", {31'b0, got}, 32'd1);
    if (got) begin
      sb.push_back('{v.port, v.err, ~v.we | v.err, v.rdata, cyc, v.lat});
      @(posedge clk);
      #1;
      a_req = 0;
      b_req = 0;
      drain();
      chk("read_strobes", rd_cnt - r0, (v.err || (v.we && v.f3 == 3'b010)) ? 0 : 1);
      chk("write_strobes", wr_cnt - w0, (!v.err && v.we) ? 1 : 0);
      if (v.we && !v.err) begin
        chk("mem_wdata", last_wdata, v.wword);
        chk("mem_addr", {20'b0, last_waddr}, {20'b0, v.addr[11:2], 2'b00});
      end
    end
    a_req = 0;
    b_req = 0;
  endtask
  initial begin
    tbl[0]  = '{0, 1, 3'b010, 12'h010, 32'hDEADBEEF, 0, 32'h0,        32'hDEADBEEF, 2};
    tbl[1]  = '{0, 0, 3'b010, 12'h010, 32'h0,        0, 32'hDEADBEEF, 32'h0,        2};
    tbl[2]  = '{0, 1, 3'b000, 12'h011, 32'h00000080, 0, 32'h0,        32'hDEAD80EF, 3};
    tbl[3]  = '{0, 0, 3'b000, 12'h011, 32'h0,        0, 32'hFFFFFF80, 32'h0,        2};
    tbl[4]  = '{0, 0, 3'b100, 12'h011, 32'h0,        0, 32'h00000080, 32'h0,        2};
    tbl[5]  = '{1, 1, 3'b010, 12'h010, 32'h80017FFF, 0, 32'h0,        32'h80017FFF, 2};
    tbl[6]  = '{0, 0, 3'b001, 12'h012, 32'h0,        0, 32'hFFFF8001, 32'h0,        2};
    tbl[7]  = '{0, 0, 3'b101, 12'h012, 32'h0,        0, 32'h00008001, 32'h0,        2};
    tbl[8]  = '{1, 0, 3'b001, 12'h013, 32'h0,        1, 32'h0,        32'h0,        1};
    tbl[9]  = '{0, 0, 3'b001, 12'h010, 32'h0,        0, 32'h00007FFF, 32'h0,        2};
    tbl[10] = '{0, 0, 3'b000, 12'h010, 32'h0,        0, 32'hFFFFFFFF, 32'h0,        2};
    tbl[11] = '{0, 1, 3'b001, 12'h012, 32'hABCD1234, 0, 32'h0,        32'h12347FFF, 3};
    tbl[12] = '{1, 0, 3'b010, 12'h010, 32'h0,        0, 32'h12347FFF, 32'h0,        2};
    tbl[13] = '{0, 1, 3'b010, 12'h011, 32'h11111111, 1, 32'h0,        32'h0,        1};
    tbl[14] = '{0, 0, 3'b011, 12'h000, 32'h0,        1, 32'h0,        32'h0,        1};
    tbl[15] = '{1, 1, 3'b100, 12'h000, 32'h22,       1, 32'h0,        32'h0,        1};
    tbl[16] = '{0, 1, 3'b010, 12'hFFC, 32'hCAFEF00D, 0, 32'h0,        32'hCAFEF00D, 2};
    tbl[17] = '{1, 0, 3'b010, 12'hFFC, 32'h0,        0, 32'hCAFEF00D, 32'h0,        2};
    tbl[18] = '{0, 0, 3'b100, 12'hFFF, 32'h0,        0, 32'h000000CA, 32'h0,        2};
    tbl[19] = '{1, 0, 3'b100, 12'h012, 32'h0,        0, 32'h00000034, 32'h0,        2};
    tbl[20] = '{0, 0, 3'b001, 12'h011, 32'h0,        1, 32'h0,        32'h0,        1};
    tbl[21] = '{1, 1, 3'b000, 12'hFFD, 32'h0000005A, 0, 32'h0,        32'hCAFE5A0D, 3};
    tbl[22] = '{0, 0, 3'b000, 12'hFFD, 32'h0,        0, 32'h0000005A, 32'h0,        2};
    tbl[23] = '{0, 0, 3'b110, 12'h000, 32'h0,        1, 32'h0,        32'h0,        1};
    repeat (3) @(negedge clk);
    a_req = 1; b_req = 1; a_funct3 = 3'b010; b_funct3 = 3'b010;
    #1;
    chk("reset_flags", {24'b0, a_gnt, b_gnt, a_done, b_done, a_err, b_err, mem_read, mem_write}, 32'd0);
    chk("reset_rdata", a_rdata | b_rdata | mem_wdata, 32'd0);
    chk("reset_mem_addr", {20'b0, mem_addr}, 32'd0);
    a_req = 0; b_req = 0;
    @(negedge clk);
    rst_n = 1;
    foreach (tbl[i]) issue(tbl[i]);
    issue('{0, 1, 3'b010, 12'h020, 32'h11223344, 0, 32'h0, 32'h11223344, 2});
    @(negedge clk);
    a_we = 1; a_funct3 = 3'b000; a_addr = 12'h021; a_wdata = 32'h55; a_req = 1;
    #1;
    chk("abort_gnt", {31'b0, a_gnt}, 32'd1);
    @(posedge clk);
    #1;
    a_req = 0;
    @(negedge clk);
    chk("abort_rmw_read", {31'b0, mem_read}, 32'd1);
    @(negedge clk);
    chk("abort_in_wr", {31'b0, mem_write}, 32'd1);
    done_cnt = 0;
    #1 rst_n = 0;
    #1;
    chk("abort_strobes_drop", {30'b0, mem_read, mem_write}, 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1;
    repeat (4) @(negedge clk);
    chk("abort_word_kept", mem[8], 32'h11223344);
    chk("abort_no_done", done_cnt, 0);
    a_we = 0; a_funct3 = 3'b010; a_addr = 12'h010;
    b_we = 0; b_funct3 = 3'b010; b_addr = 12'hFFC;
    a_req = 1; b_req = 1;
    for (int w = 0; w < 40 && order.size() < 4; w++) begin
      #1;
      if (a_gnt && b_gnt) chk("dual_gnt", 32'd1, 32'd0);
      if (a_gnt) begin
        sb.push_back('{0, 0, 1, 32'h12347FFF, cyc, 2});
        order.push_back(0);
      end
      if (b_gnt) begin
        sb.push_back('{1, 0, 1, 32'hCAFE5A0D, cyc, 2});
        order.push_back(1);
      end
      if (order.size() == 4) begin
        @(posedge clk);
        #1;
        a_req = 0;
        b_req = 0;
      end else @(negedge clk);
    end
    a_req = 0;
    b_req = 0;
    chk("rr_count", order.size(), 4);
    for (int i = 0; i < order.size() && i < 4; i++) chk("rr_order", {31'b0, order[i]}, i % 2);
    drain();
    chk("strobe_overlap", overlap_cnt, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
